// File: rtl/nlm_pkg.sv
// Shared definitions for the NLM weight normaliser: PE weight width,
// normaliser FSM states and accumulator width helpers.
package nlm_pkg;

    // Weight width produced by the PE array (weight_o).
    localparam int PE_WEIGHT_WIDTH = 8;

    typedef enum logic [1:0] {
        ACC = 2'd0,
        FIN = 2'd1,
        DIV = 2'd2,
        OUT = 2'd3
    } state_e;

    // Weight sum: one weight per candidate.
    function automatic int wsum_width(input int weight_w, input int cnt_w);
        return weight_w + cnt_w;
    endfunction

    // Product sum: one weight*pixel per candidate, plus a bit for the rounding add.
    function automatic int psum_width(input int weight_w, input int data_w, input int cnt_w);
        return weight_w + data_w + cnt_w + 1;
    endfunction

endpackage

// File: rtl/seq_divider.sv
// Restoring sequential divider, one quotient bit per cycle, MSB first.
// A quotient that does not fit in QUO_WIDTH bits saturates to all ones.
// done/quotient are valid in the cycle of the final step so the caller can
// register the result on that same edge.
module seq_divider
    import nlm_pkg::*;
#(
    parameter int NUM_WIDTH = 28,
    parameter int DEN_WIDTH = 15,
    parameter int QUO_WIDTH = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [NUM_WIDTH-1:0] num,
    input  logic [DEN_WIDTH-1:0] den,
    output logic                 busy,
    output logic                 done,
    output logic [QUO_WIDTH-1:0] quotient
);

    localparam int STEP_WIDTH = $clog2(QUO_WIDTH + 1);

    logic                  busy_q, busy_d;
    logic                  sat_q, sat_d;
    logic [STEP_WIDTH-1:0] step_q, step_d;
    logic [DEN_WIDTH-1:0]  rem_q, rem_d;
    logic [DEN_WIDTH-1:0]  den_q, den_d;
    logic [QUO_WIDTH-1:0]  low_q, low_d;
    logic [QUO_WIDTH-1:0]  quo_q, quo_d;

    logic [NUM_WIDTH-1:0]  high_s;
    logic [DEN_WIDTH:0]    trial_s;
    logic [DEN_WIDTH-1:0]  diff_s;
    logic                  qbit_s;
    logic [QUO_WIDTH-1:0]  quo_next_s;

    // The bits above the quotient range seed the remainder; if they already
    // reach the divisor the quotient cannot fit and is saturated.
    assign high_s     = num >> QUO_WIDTH;
    assign trial_s    = {rem_q, low_q[QUO_WIDTH-1]};
    assign qbit_s     = (trial_s >= {1'b0, den_q});
    assign diff_s     = trial_s[DEN_WIDTH-1:0] - den_q;
    assign quo_next_s = {quo_q[QUO_WIDTH-2:0], qbit_s};

    assign busy     = busy_q;
    assign done     = busy_q && (step_q == STEP_WIDTH'(1));
    assign quotient = sat_q ? {QUO_WIDTH{1'b1}} : quo_next_s;

    // Next-state: load on start when idle, otherwise shift/subtract one bit.
    always_comb begin
        busy_d = busy_q;
        sat_d  = sat_q;
        step_d = step_q;
        rem_d  = rem_q;
        den_d  = den_q;
        low_d  = low_q;
        quo_d  = quo_q;
        if (busy_q) begin
            rem_d  = qbit_s ? diff_s : trial_s[DEN_WIDTH-1:0];
            low_d  = low_q << 1'b1;
            quo_d  = quo_next_s;
            step_d = step_q - STEP_WIDTH'(1);
            if (step_q == STEP_WIDTH'(1)) begin
                busy_d = 1'b0;
            end else begin
                busy_d = 1'b1;
            end
        end else if (start) begin
            busy_d = 1'b1;
            sat_d  = (high_s >= NUM_WIDTH'(den));
            step_d = STEP_WIDTH'(QUO_WIDTH);
            rem_d  = DEN_WIDTH'(high_s);
            den_d  = den;
            low_d  = num[QUO_WIDTH-1:0];
            quo_d  = '0;
        end else begin
            busy_d = 1'b0;
        end
    end

    // Divider state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= 1'b0;
            sat_q  <= 1'b0;
            step_q <= '0;
            rem_q  <= '0;
            den_q  <= '0;
            low_q  <= '0;
            quo_q  <= '0;
        end else begin
            busy_q <= busy_d;
            sat_q  <= sat_d;
            step_q <= step_d;
            rem_q  <= rem_d;
            den_q  <= den_d;
            low_q  <= low_d;
            quo_q  <= quo_d;
        end
    end

endmodule

// File: rtl/nlm_weight_normalizer.sv
// NLM weight normaliser: accumulates the PE (weight, pixel) stream for one
// output pixel, substitutes the max weight for the centre candidate, then
// divides with round-half-up and presents the result on valid/ready.
module nlm_weight_normalizer
    import nlm_pkg::*;
#(
    parameter int DATA_WIDTH   = 12,
    parameter int WEIGHT_WIDTH = PE_WEIGHT_WIDTH,
    parameter int MAX_CAND     = 81,
    parameter int CNT_WIDTH    = $clog2(MAX_CAND + 1),
    parameter int WSUM_WIDTH   = wsum_width(WEIGHT_WIDTH, CNT_WIDTH),
    parameter int PSUM_WIDTH   = psum_width(WEIGHT_WIDTH, DATA_WIDTH, CNT_WIDTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [WEIGHT_WIDTH-1:0] in_weight,
    input  logic [DATA_WIDTH-1:0]   in_pixel,
    input  logic                    in_center,
    input  logic                    in_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_WIDTH-1:0]   out_pixel,
    output logic [CNT_WIDTH-1:0]    out_count,
    output logic                    out_ovf
);

    localparam int PROD_WIDTH = WEIGHT_WIDTH + DATA_WIDTH;

    state_e                  state_q, state_d;
    logic [WSUM_WIDTH-1:0]   wsum_q, wsum_d;
    logic [PSUM_WIDTH-1:0]   psum_q, psum_d;
    logic [WEIGHT_WIDTH-1:0] maxw_q, maxw_d;
    logic [DATA_WIDTH-1:0]   center_q, center_d;
    logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
    logic                    ovf_q, ovf_d;
    logic [DATA_WIDTH-1:0]   out_pixel_q, out_pixel_d;
    logic                    out_valid_q, out_valid_d;
    logic                    in_ready_q, in_ready_d;

    logic                    accept_s;
    logic                    clear_s;
    logic [PROD_WIDTH-1:0]   beat_prod_s;
    logic [PROD_WIDTH-1:0]   center_prod_s;
    logic [WSUM_WIDTH-1:0]   wsum_fin_s;
    logic [PSUM_WIDTH-1:0]   psum_fin_s;
    logic [PSUM_WIDTH-1:0]   num_s;
    logic                    div_start_s;
    logic                    div_busy_s;
    logic                    div_done_s;
    logic [DATA_WIDTH-1:0]   div_quot_s;

    assign accept_s      = in_valid && in_ready_q;
    assign beat_prod_s   = PROD_WIDTH'(in_weight) * PROD_WIDTH'(in_pixel);
    assign center_prod_s = PROD_WIDTH'(maxw_q) * PROD_WIDTH'(center_q);
    // Final sums with the centre candidate weighted by the largest weight seen.
    assign wsum_fin_s    = wsum_q + WSUM_WIDTH'(maxw_q);
    assign psum_fin_s    = psum_q + PSUM_WIDTH'(center_prod_s);
    assign num_s         = psum_fin_s + PSUM_WIDTH'(wsum_fin_s >> 1'b1);

    seq_divider #(
        .NUM_WIDTH (PSUM_WIDTH),
        .DEN_WIDTH (WSUM_WIDTH),
        .QUO_WIDTH (DATA_WIDTH)
    ) u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start_s),
        .num      (num_s),
        .den      (wsum_fin_s),
        .busy     (div_busy_s),
        .done     (div_done_s),
        .quotient (div_quot_s)
    );

    // Accumulate / finalise / divide / output sequencing.
    always_comb begin
        state_d     = state_q;
        wsum_d      = wsum_q;
        psum_d      = psum_q;
        maxw_d      = maxw_q;
        center_d    = center_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        out_pixel_d = out_pixel_q;
        out_valid_d = out_valid_q;
        in_ready_d  = in_ready_q;
        div_start_s = 1'b0;
        clear_s     = 1'b0;
        case (state_q)
            ACC: begin
                if (accept_s) begin
                    if (cnt_q == CNT_WIDTH'(MAX_CAND)) begin
                        ovf_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_WIDTH'(1);
                    end
                    if (in_center) begin
                        center_d = in_pixel;
                    end else begin
                        wsum_d = wsum_q + WSUM_WIDTH'(in_weight);
                        psum_d = psum_q + PSUM_WIDTH'(beat_prod_s);
                        if (in_weight > maxw_q) begin
                            maxw_d = in_weight;
                        end else begin
                            maxw_d = maxw_q;
                        end
                    end
                    if (in_last) begin
                        state_d    = FIN;
                        in_ready_d = 1'b0;
                    end else begin
                        state_d = ACC;
                    end
                end else begin
                    state_d = ACC;
                end
            end
            FIN: begin
                wsum_d     = wsum_fin_s;
                psum_d     = psum_fin_s;
                in_ready_d = 1'b0;
                if (wsum_fin_s == '0) begin
                    out_pixel_d = center_q;
                    out_valid_d = 1'b1;
                    state_d     = OUT;
                end else begin
                    div_start_s = 1'b1;
                    state_d     = DIV;
                end
            end
            DIV: begin
                if (div_done_s) begin
                    out_pixel_d = div_quot_s;
                    out_valid_d = 1'b1;
                    state_d     = OUT;
                end else if (!div_busy_s) begin
                    // Divider lost its operation: drop the frame rather than hang.
                    clear_s    = 1'b1;
                    in_ready_d = 1'b1;
                    state_d    = ACC;
                end else begin
                    state_d = DIV;
                end
            end
            OUT: begin
                if (out_valid_q && out_ready) begin
                    clear_s     = 1'b1;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = ACC;
                end else begin
                    state_d = OUT;
                end
            end
            default: begin
                clear_s     = 1'b1;
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                state_d     = ACC;
            end
        endcase
        if (clear_s) begin
            wsum_d   = '0;
            psum_d   = '0;
            maxw_d   = '0;
            center_d = '0;
            cnt_d    = '0;
            ovf_d    = 1'b0;
        end else begin
            ovf_d = ovf_d;
        end
    end

    // State, accumulator and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ACC;
            wsum_q      <= '0;
            psum_q      <= '0;
            maxw_q      <= '0;
            center_q    <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            out_pixel_q <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            wsum_q      <= wsum_d;
            psum_q      <= psum_d;
            maxw_q      <= maxw_d;
            center_q    <= center_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            out_pixel_q <= out_pixel_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_pixel = out_pixel_q;
    assign out_count = cnt_q;
    assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_nlm_weight_normalizer.sv
// Self-checking bench for nlm_weight_normalizer: frame table plus random
// frames, results checked from a scoreboard queue at the output handshake.
module tb_nlm_weight_normalizer;

    localparam int DW = 12;
    localparam int WW = 8;
    localparam int CW = 7;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [WW-1:0] in_weight;
    logic [DW-1:0] in_pixel;
    logic          in_center;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_pixel;
    logic [CW-1:0] out_count;
    logic          out_ovf;

    nlm_weight_normalizer dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_weight (in_weight),
        .in_pixel  (in_pixel),
        .in_center (in_center),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pixel (out_pixel),
        .out_count (out_count),
        .out_ovf   (out_ovf)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int            nb;
        logic [WW-1:0] w0, w1;
        logic [DW-1:0] p0, p1;
        logic          has_c;
        logic [DW-1:0] cpx;
        logic [DW-1:0] exp_px;
        int            exp_cnt;
        logic          exp_ovf;
        int            exp_lat;
    } vec_t;

    typedef struct {
        logic [DW-1:0] px;
        logic [CW-1:0] cnt;
        logic          ovf;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   last_acc = 0;
    vec_t vecs[8];

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, required %0d", name, act, exp);
    endtask

    // Output monitor: compare every handshaken result with the scoreboard.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_output: got pixel %0d, required no output", out_pixel);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("out_pixel", out_pixel, e.px);
                check("out_count", out_count, e.cnt);
                check("out_ovf", out_ovf, e.ovf);
            end
        end
    end

    // Called just after a negedge; returns at the negedge after acceptance.
    task automatic send_beat(input logic [WW-1:0] w, input logic [DW-1:0] p,
                             input logic c, input logic l);
        int guard = 0;
        in_valid = 1'b1; in_weight = w; in_pixel = p; in_center = c; in_last = l;
        while (!in_ready && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 300) begin
            n_checks++;
            $display("FAIL in_ready_timeout: in_ready 0, required 1");
        end
        @(posedge clk);
        @(negedge clk);
        last_acc = cyc;
        in_valid = 1'b0; in_center = 1'b0; in_last = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input bit push);
        if (push) sb.push_back(exp_t'{v.exp_px, CW'(v.exp_cnt), v.exp_ovf});
        for (int i = 0; i < v.nb; i++) begin
            send_beat((i % 2 == 0) ? v.w0 : v.w1, (i % 2 == 0) ? v.p0 : v.p1,
                      1'b0, (!v.has_c) && (i == v.nb - 1));
        end
        // Centre beat carries a large bogus weight that must be ignored.
        if (v.has_c) send_beat(8'd250, v.cpx, 1'b1, 1'b1);
        if (v.exp_lat != 0) begin
            int t = last_acc;
            int g = 0;
            while (!out_valid && g < 100) begin
                @(negedge clk);
                g++;
            end
            check("latency", cyc + 1 - t, v.exp_lat);
        end
    endtask

    task automatic wait_drain();
        int g = 0;
        while (sb.size() != 0 && g < 500) begin
            @(negedge clk);
            g++;
        end
        check("drain", sb.size(), 0);
    endtask

    function automatic vec_t model(input vec_t v);
        vec_t   r = v;
        longint ws = 0, ps = 0, mw = 0, w, p, c;
        for (int i = 0; i < v.nb; i++) begin
            w = (i % 2 == 0) ? v.w0 : v.w1;
            p = (i % 2 == 0) ? v.p0 : v.p1;
            ws += w; ps += w * p;
            if (w > mw) mw = w;
        end
        c = v.has_c ? v.cpx : 0;
        ws += mw; ps += mw * c;
        r.exp_px  = (ws == 0) ? DW'(c) : DW'((ps + ws / 2) / ws);
        r.exp_cnt = v.nb + (v.has_c ? 1 : 0);
        r.exp_ovf = 1'b0;
        r.exp_lat = (ws == 0) ? 2 : 14;
        return r;
    endfunction

    initial begin
        vec_t v;
        rst = 1'b1; in_valid = 1'b0; in_weight = '0; in_pixel = '0;
        in_center = 1'b0; in_last = 1'b0; out_ready = 1'b1;

        vecs[0] = '{3, 8'd255, 8'd255, 12'd100, 12'd100, 1'b1, 12'd100, 12'd100, 4, 1'b0, 14};
        vecs[1] = '{2, 8'd255, 8'd85, 12'd200, 12'd40, 1'b1, 12'd120, 12'd143, 3, 1'b0, 0};
        vecs[2] = '{4, 8'd0, 8'd0, 12'd500, 12'd900, 1'b1, 12'd777, 12'd777, 5, 1'b0, 2};
        vecs[3] = '{0, 8'd0, 8'd0, 12'd0, 12'd0, 1'b1, 12'd300, 12'd300, 1, 1'b0, 2};
        vecs[4] = '{82, 8'd1, 8'd1, 12'd10, 12'd10, 1'b0, 12'd0, 12'd10, 81, 1'b1, 14};
        vecs[5] = '{2, 8'd10, 8'd30, 12'd1000, 12'd2000, 1'b0, 12'd0, 12'd1000, 2, 1'b0, 0};
        vecs[6] = '{1, 8'd255, 8'd0, 12'd4095, 12'd0, 1'b1, 12'd4095, 12'd4095, 2, 1'b0, 0};
        vecs[7] = '{1, 8'd128, 8'd128, 12'd50, 12'd50, 1'b1, 12'd50, 12'd50, 2, 1'b0, 14};

        repeat (3) @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_pixel", out_pixel, 0);
        check("rst_out_count", out_count, 0);
        check("rst_out_ovf", out_ovf, 0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", in_ready, 1);
        check("post_rst_out_valid", out_valid, 0);

        for (int i = 0; i < 7; i++) run_vec(vecs[i], 1'b1);
        wait_drain();

        // Backpressure: result held while out_ready is low.
        out_ready = 1'b0;
        run_vec(vecs[1], 1'b1);
        begin
            int g = 0;
            while (!out_valid && g < 100) begin
                @(negedge clk);
                g++;
            end
        end
        for (int k = 0; k < 5; k++) begin
            check("bp_out_valid", out_valid, 1);
            check("bp_out_pixel", out_pixel, 143);
            check("bp_in_ready", in_ready, 0);
            @(negedge clk);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("post_hs_in_ready", in_ready, 1);
        check("post_hs_out_valid", out_valid, 0);
        run_vec(vecs[0], 1'b1);
        wait_drain();

        // Reset in the middle of a division discards that frame.
        run_vec(vecs[1], 1'b0);
        while (cyc < last_acc + 4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_out_pixel", out_pixel, 0);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_in_ready", in_ready, 1);
        check("midrst_out_valid_after", out_valid, 0);
        run_vec(vecs[7], 1'b1);
        wait_drain();

        // Random frames against the reference model.
        for (int i = 0; i < 6; i++) begin
            v.nb    = $urandom_range(6, 1);
            v.w0    = WW'($urandom_range(255));
            v.w1    = WW'($urandom_range(255));
            v.p0    = DW'($urandom_range(4095));
            v.p1    = DW'($urandom_range(4095));
            v.has_c = 1'($urandom_range(1));
            v.cpx   = DW'($urandom_range(4095));
            run_vec(model(v), 1'b1);
        end
        wait_drain();
        repeat (20) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/nlm_weight_normalizer.md
Name: nlm_weight_normalizer

Overview:
- Consumer side of the NLM PE array. Accepts the per-candidate (weight, search pixel) stream that the PEs emit and accumulates the weights and the weight×pixel products over one output pixel's candidate set.
- Substitutes the maximum observed weight for the centre candidate, whose PE weight is forced to 0.
- Performs a rounded sequential division and presents the denoised pixel on a valid/ready output.
- Sits between the PE array's weight/pixel outputs and the output line writer.

Parameters:
- DATA_WIDTH, 12, pixel width.
- WEIGHT_WIDTH, 8, weight width; matches PE weight output.
- MAX_CAND, 81, maximum candidates per output pixel. Default is (13-5+1)^2.
- CNT_WIDTH, $clog2(MAX_CAND+1), candidate counter width.
- WSUM_WIDTH, WEIGHT_WIDTH+CNT_WIDTH, weight sum width.
- PSUM_WIDTH, WEIGHT_WIDTH+DATA_WIDTH+CNT_WIDTH+1, product sum width. The +1 covers the rounding add.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  candidate beat valid.
- in_ready  out  1  block accepts beat.
- in_weight  in  WEIGHT_WIDTH  candidate weight (PE weight_o).
- in_pixel  in  DATA_WIDTH  candidate search pixel (PE srh_bit_o).
- in_center  in  1  beat is the centre candidate; its in_weight is ignored.
- in_last  in  1  final beat of the candidate set.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_pixel  out  DATA_WIDTH  denoised pixel.
- out_count  out  CNT_WIDTH  beats accepted for this result, saturating at MAX_CAND.
- out_ovf  out  1  more than MAX_CAND beats were accepted for this result.

Behaviour:
- Clocking and reset:
  - One clock domain, clk.
  - rst is asynchronous and active-high.
  - While rst is asserted: state=ACC; all accumulators, max weight, centre pixel and counter are 0; out_valid=0, out_pixel=0, out_count=0, out_ovf=0.
  - in_ready is 1 after reset.
  - Reset mid-frame or mid-division discards the partial result; no output is produced for it.
- States: ACC, FIN, DIV, OUT.
- ACC:
  - in_ready=1.
  - Beat accepted when in_valid && in_ready.
  - Non-centre beat:
    - wsum += in_weight; psum += in_weight*in_pixel.
    - maxw = max(maxw, in_weight).
  - Centre beat: centre register <= in_pixel; sums and maxw unchanged.
  - If both in_center and in_last are set, the beat acts as centre and last.
  - Every accepted beat increments the counter, saturating at MAX_CAND. A beat accepted while the counter equals MAX_CAND sets the ovf flag; accumulation still proceeds.
  - An accepted beat with in_last moves the block to FIN on the next edge.
- FIN (1 cycle, in_ready=0):
  - wsum += maxw; psum += maxw*centre.
  - If no centre beat arrived, centre=0.
  - If the final wsum is 0: out_pixel <= centre, go to OUT.
  - Otherwise: load the divider with numerator psum+(wsum>>1) (round half up) and divisor wsum, go to DIV.
- DIV (exactly DATA_WIDTH cycles, in_ready=0):
  - Restoring division, one quotient bit per cycle, MSB first.
  - If the true quotient reaches 2^DATA_WIDTH, out_pixel saturates to 2^DATA_WIDTH-1.
  - On completion: out_pixel <= quotient, go to OUT.
- OUT:
  - out_valid=1; in_ready=0.
  - out_pixel, out_count and out_ovf are held stable until out_valid && out_ready.
  - On the handshake edge: clear sums, maxw, centre, counter and ovf; go to ACC.
  - out_valid falls and in_ready rises in the next cycle. There is no bypass: a new beat cannot be accepted in the handshake cycle.
- Latency, with the last beat accepted at edge t:
  - Nonzero-weight path: out_valid is first high in cycle t+2+DATA_WIDTH.
  - Zero-weight path: out_valid is first high in cycle t+2.
- Arithmetic: all unsigned. Products are WEIGHT_WIDTH+DATA_WIDTH bits, zero-extended into psum.

Decomposition:
- Package nlm_pkg:
  - WEIGHT_WIDTH constant, shared with the PEs.
  - State enum {ACC, FIN, DIV, OUT}.
  - Width helper functions for WSUM/PSUM.
- Sub-module seq_divider:
  - Parameterised numerator, divisor and quotient widths.
  - start/busy/done handshake.
  - Restoring algorithm, saturating quotient.
- Accumulate logic and FSM live in nlm_weight_normalizer.

Test Plan:
- Uniform frame: 3 beats (w=255, px=100), then centre beat px=100 with last → out_pixel=100, out_count=4, out_valid first high at t+14 (DATA_WIDTH=12).
- Weighted frame: (255, 200), (85, 40), then centre px=120 with last → wsum=595, psum=85000, numerator 85297, out_pixel=143, out_ovf=0.
- All-zero weights: 4 beats w=0, centre px=777 → out_pixel=777, out_valid first high at t+2; divider not started.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid → out_pixel stable, in_ready=0 throughout; after the handshake, in_ready=1 next cycle, and a following frame computes correctly from cleared sums.
- Reset during DIV (cycle t+5) → out_valid=0 and in_ready=1 after release; next frame (w=128, px=50; centre px=50) → out_pixel=50.
- Overflow: 82 beats w=1, px=10 with MAX_CAND=81 → out_count=81, out_ovf=1, out_pixel=10. Separately, a single beat with in_center=1 and in_last=1, px=300 → out_pixel=300 (wsum=0 path).
